// File: rtl/book_update_arbiter_if.sv
// ---------------------------------------------------------------------------
// book_update_arbiter_if
//
// Purpose: bundles the feed-side and book-side handshake/data signals of the
// book update arbiter.
//
// Signals:
//   feed_valid  [NUM_FEEDS]     per-feed update present
//   feed_ready  [NUM_FEEDS]     per-feed accept (at most one bit set)
//   feed_price  [NUM_FEEDS*PW]  feed i at [i*PW +: PW]
//   feed_size   [NUM_FEEDS*SW]  feed i at [i*SW +: SW]
//   feed_side   [NUM_FEEDS]     0 = bid, 1 = ask
//   book_valid/book_ready       output stage handshake
//   book_price/size/side/src    registered winning update and its feed index
//
// Modports: master = feed handlers plus order book (environment side),
//           slave  = the arbiter.
// ---------------------------------------------------------------------------
interface book_update_arbiter_if #(
    parameter int NUM_FEEDS = 4,
    parameter int PW        = 32,
    parameter int SW        = 32
);
    localparam int IW = $clog2(NUM_FEEDS);

    logic [NUM_FEEDS-1:0]    feed_valid;
    logic [NUM_FEEDS-1:0]    feed_ready;
    logic [NUM_FEEDS*PW-1:0] feed_price;
    logic [NUM_FEEDS*SW-1:0] feed_size;
    logic [NUM_FEEDS-1:0]    feed_side;

    logic                    book_valid;
    logic                    book_ready;
    logic [PW-1:0]           book_price;
    logic [SW-1:0]           book_size;
    logic                    book_side;
    logic [IW-1:0]           book_src;

    modport master (
        output feed_valid, feed_price, feed_size, feed_side, book_ready,
        input  feed_ready, book_valid, book_price, book_size, book_side, book_src
    );

    modport slave (
        input  feed_valid, feed_price, feed_size, feed_side, book_ready,
        output feed_ready, book_valid, book_price, book_size, book_side, book_src
    );
endinterface

// File: rtl/book_update_arbiter.sv
// ---------------------------------------------------------------------------
// book_update_arbiter
//
// Purpose: round-robin merge of NUM_FEEDS top-of-book update streams onto the
// single order-book update port. The winning update is registered in a
// one-deep output stage with valid/ready backpressure. A freeze handshake
// (freeze_req/freeze_ack) stops granting and drains the output stage so the
// book can be quiesced, e.g. for snapshots.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   bus         book_update_arbiter_if.slave (feed and book handshakes)
//   freeze_req  request to stop granting
//   freeze_ack  registered, high only while frozen
//   stat_clr    synchronous clear of all counters       (ARB_STATS_EN only)
//   stat_count  per-feed saturating accepted counts,
//               feed i at [i*CNT_W +: CNT_W]            (ARB_STATS_EN only)
//
// Optional feature: define ARB_STATS_EN to build the per-feed statistics
// counters and the stat_clr/stat_count ports.
// ---------------------------------------------------------------------------
module book_update_arbiter #(
    parameter int NUM_FEEDS = 4,
    parameter int PW        = 32,
    parameter int SW        = 32
`ifdef ARB_STATS_EN
    ,
    parameter int CNT_W     = 32
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    book_update_arbiter_if.slave       bus,
    input  logic                       freeze_req,
    output logic                       freeze_ack
`ifdef ARB_STATS_EN
    ,
    input  logic                       stat_clr,
    output logic [NUM_FEEDS*CNT_W-1:0] stat_count
`endif
);
    localparam int IW = $clog2(NUM_FEEDS);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        FROZEN
    } state_t;

    state_t               state;
    logic [IW-1:0]        ptr;

    logic                 book_valid_q;
    logic [PW-1:0]        book_price_q;
    logic [SW-1:0]        book_size_q;
    logic                 book_side_q;
    logic [IW-1:0]        book_src_q;

    logic                 can_load;
    logic                 grant_en;
    logic                 grant_any;
    logic [IW-1:0]        grant_idx;
    logic                 transfer;
    logic [NUM_FEEDS-1:0] grant_vec;

    // Feed index k positions above base, wrapping modulo NUM_FEEDS (which
    // need not be a power of two).
    function automatic int rr_index(input logic [IW-1:0] base, input int k);
        int idx;
        idx = int'(base) + k;
        if (idx >= NUM_FEEDS) idx = idx - NUM_FEEDS;
        return idx;
    endfunction

    // Round-robin search: first valid feed at or above ptr, wrapping.
    always_comb begin
        // NOTE: every always_comb output is given a default first, so no path
        // leaves it unassigned and no latch is inferred.
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_FEEDS; k++) begin
            if (!grant_any && bus.feed_valid[rr_index(ptr, k)]) begin
                grant_any = 1'b1;
                grant_idx = IW'(rr_index(ptr, k));
            end
        end
    end

    assign can_load = !book_valid_q || bus.book_ready;
    // rst gates the grant so feed_ready is low for the whole reset pulse.
    assign grant_en = !rst && (state == RUN) && !freeze_req && can_load;
    assign transfer = grant_en && grant_any;

    always_comb begin
        grant_vec = '0;
        if (transfer) grant_vec[grant_idx] = 1'b1;
    end

    assign bus.feed_ready = grant_vec;
    assign bus.book_valid = book_valid_q;
    assign bus.book_price = book_price_q;
    assign bus.book_size  = book_size_q;
    assign bus.book_side  = book_side_q;
    assign bus.book_src   = book_src_q;

    // Output stage and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            book_valid_q <= 1'b0;
            book_price_q <= '0;
            book_size_q  <= '0;
            book_side_q  <= 1'b0;
            book_src_q   <= '0;
            ptr          <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            if (transfer) begin
                book_valid_q <= 1'b1;
                book_price_q <= bus.feed_price[int'(grant_idx)*PW +: PW];
                book_size_q  <= bus.feed_size[int'(grant_idx)*SW +: SW];
                book_side_q  <= bus.feed_side[grant_idx];
                book_src_q   <= grant_idx;
                ptr          <= (grant_idx == IW'(NUM_FEEDS - 1)) ? '0 : grant_idx + 1'b1;
            end else if (bus.book_ready) begin
                // Retire without reload; data registers keep their value.
                book_valid_q <= 1'b0;
            end
        end
    end

    // Freeze FSM. DRAIN waits until the output stage can empty, so FROZEN
    // is only reached with nothing left to present to the book.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            freeze_ack <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (freeze_req) state <= DRAIN;
                end
                DRAIN: begin
                    if (!freeze_req) begin
                        state <= RUN;
                    end else if (can_load) begin
                        state      <= FROZEN;
                        freeze_ack <= 1'b1;
                    end
                end
                FROZEN: begin
                    if (!freeze_req) begin
                        state      <= RUN;
                        freeze_ack <= 1'b0;
                    end
                end
                default: begin
                    state      <= RUN;
                    freeze_ack <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [NUM_FEEDS];

    // Saturating per-feed transfer counters; a clear wins over an increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the counters are individual flops rather than a RAM, so
            // they take the asynchronous reset like any other state.
            for (int i = 0; i < NUM_FEEDS; i++) cnt_q[i] <= '0;
        end else if (stat_clr) begin
            for (int i = 0; i < NUM_FEEDS; i++) cnt_q[i] <= '0;
        end else if (transfer && (cnt_q[grant_idx] != '1)) begin
            cnt_q[grant_idx] <= cnt_q[grant_idx] + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_FEEDS; g++) begin : g_stat
        assign stat_count[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`endif
endmodule

// File: tb/tb_book_update_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_book_update_arbiter
//
// Directed scenarios with literal expectations followed by a randomized run.
// A queue-based model of the arbiter rules is checked against the DUT at
// every falling clock edge.
// ---------------------------------------------------------------------------
module tb_book_update_arbiter;
    localparam int N  = 4;
    localparam int PW = 32;
    localparam int SW = 32;
    localparam int IW = $clog2(N);
`ifdef ARB_STATS_EN
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`endif

    logic clk        = 1'b0;
    logic rst        = 1'b1;
    logic freeze_req = 1'b0;
    logic freeze_ack;
`ifdef ARB_STATS_EN
    logic                 stat_clr = 1'b0;
    logic [N*CNT_W-1:0]   stat_count;
`endif

    always #5 clk = ~clk;

    book_update_arbiter_if #(.NUM_FEEDS(N), .PW(PW), .SW(SW)) bus ();

    book_update_arbiter #(
        .NUM_FEEDS(N),
        .PW       (PW),
        .SW       (SW)
`ifdef ARB_STATS_EN
        ,
        .CNT_W    (CNT_W)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .freeze_req(freeze_req),
        .freeze_ack(freeze_ack)
`ifdef ARB_STATS_EN
        ,
        .stat_clr  (stat_clr),
        .stat_count(stat_count)
`endif
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [PW-1:0] price;
        logic [SW-1:0] size;
        logic          side;
        int            src;
    } upd_t;

    upd_t pend_q[$];   // updates accepted but not yet retired by the book
    int   m_ptr;       // next feed index that has priority
    int   m_phase;     // 0 granting, 1 waiting for output to drain, 2 frozen
    int   m_cnt [N];

    function automatic int rr_winner(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic int oh_idx(input logic [N-1:0] v);
        int found;
        found = -1;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                if (found != -1) return -2;
                found = i;
            end
        end
        return found;
    endfunction

    task automatic model_reset();
        pend_q.delete();
        m_ptr   = 0;
        m_phase = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    int mw;
    bit m_can_load, m_grant;

    always @(posedge clk) begin
        if (rst) begin
            model_reset();
        end else begin
            m_can_load = (pend_q.size() == 0) || bus.book_ready;
            mw         = rr_winner(bus.feed_valid, m_ptr);
            m_grant    = (m_phase == 0) && !freeze_req && m_can_load && (mw >= 0);
            if (pend_q.size() != 0 && bus.book_ready) pend_q.delete(0);
            if (m_grant) begin
                pend_q.push_back('{price: bus.feed_price[mw*PW +: PW],
                                   size:  bus.feed_size[mw*SW +: SW],
                                   side:  bus.feed_side[mw],
                                   src:   mw});
                m_ptr = (mw + 1) % N;
            end
`ifdef ARB_STATS_EN
            if (stat_clr) begin
                for (int i = 0; i < N; i++) m_cnt[i] = 0;
            end else if (m_grant && m_cnt[mw] < CNT_MAX) begin
                m_cnt[mw]++;
            end
`endif
            case (m_phase)
                0:       if (freeze_req) m_phase = 1;
                1:       if (!freeze_req) m_phase = 0; else if (m_can_load) m_phase = 2;
                default: if (!freeze_req) m_phase = 0;
            endcase
        end
    end

    logic [N-1:0] exp_ready;
    int           cw;

    always @(negedge clk) begin
        if (rst) model_reset();
        exp_ready = '0;
        if (!rst && m_phase == 0 && !freeze_req && (pend_q.size() == 0 || bus.book_ready)) begin
            cw = rr_winner(bus.feed_valid, m_ptr);
            if (cw >= 0) exp_ready[cw] = 1'b1;
        end
        check("feed_ready", bus.feed_ready, exp_ready);
        check("book_valid", bus.book_valid, pend_q.size() != 0);
        if (pend_q.size() != 0) begin
            check("book_price", bus.book_price, pend_q[0].price);
            check("book_size",  bus.book_size,  pend_q[0].size);
            check("book_side",  bus.book_side,  pend_q[0].side);
            check("book_src",   bus.book_src,   pend_q[0].src);
        end
        check("freeze_ack", freeze_ack, m_phase == 2);
`ifdef ARB_STATS_EN
        for (int i = 0; i < N; i++)
            check($sformatf("stat_count%0d", i), stat_count[i*CNT_W +: CNT_W], m_cnt[i]);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_payload();
        for (int i = 0; i < N; i++) begin
            bus.feed_price[i*PW +: PW] = $urandom;
            bus.feed_size[i*SW +: SW]  = $urandom;
            bus.feed_side[i]           = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        int            g [6];
        int            s [6];
        int            exp_g [6];
        logic [PW-1:0] held_p;
        logic [SW-1:0] held_s;

        exp_g = '{0, 1, 2, 3, 0, 1};
        bus.feed_valid = '1;
        bus.feed_price = '0;
        bus.feed_size  = '0;
        bus.feed_side  = '0;
        bus.book_ready = 1'b1;
        rand_payload();

        // Reset values, with every feed requesting.
        step();
        @(negedge clk);
        check("rst_feed_ready", bus.feed_ready, 0);
        check("rst_book_valid", bus.book_valid, 0);
        check("rst_book_price", bus.book_price, 0);
        check("rst_book_size",  bus.book_size,  0);
        check("rst_book_side",  bus.book_side,  0);
        check("rst_book_src",   bus.book_src,   0);
        check("rst_freeze_ack", freeze_ack,     0);
        step();
        rst = 1'b0;

        // All feeds valid: grants rotate 0,1,2,3,0,1; book_src trails by one.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            g[i] = oh_idx(bus.feed_ready);
            s[i] = int'(bus.book_src);
            step();
            rand_payload();
        end
        for (int i = 0; i < 6; i++) check($sformatf("rr_grant%0d", i), g[i], exp_g[i]);
        for (int i = 1; i < 6; i++) check($sformatf("rr_src%0d", i), s[i], exp_g[i-1]);

        // Only feed 2 valid for five cycles.
        bus.feed_valid = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("solo_ready", bus.feed_ready, 4'b0100);
            if (i > 0) check("solo_src", bus.book_src, 2);
            step();
            rand_payload();
        end

        // Backpressure: held update stays stable, no grants.
        bus.feed_valid = '1;
        bus.book_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin
                held_p = bus.book_price;
                held_s = bus.book_size;
                check("solo_last_src", bus.book_src, 2);
            end else begin
                check("bp_price_stable", bus.book_price, held_p);
                check("bp_size_stable",  bus.book_size,  held_s);
            end
            check("bp_no_ready", bus.feed_ready, 0);
            check("bp_valid",    bus.book_valid, 1);
            step();
            rand_payload();
        end
        bus.book_ready = 1'b1;
        @(negedge clk);
        check("bp_release_grant", oh_idx(bus.feed_ready), 3);
        check("bp_release_price", bus.book_price, held_p);
        step();
        @(negedge clk);
        check("bp_next_src", bus.book_src, 3);
        check("bp_next_valid", bus.book_valid, 1);
        step();

        // Freeze with a pending output held by backpressure.
        freeze_req     = 1'b1;
        bus.book_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("drain_ack",   freeze_ack,     0);
            check("drain_ready", bus.feed_ready, 0);
            check("drain_valid", bus.book_valid, 1);
            step();
        end
        bus.book_ready = 1'b1;
        @(negedge clk);
        check("drain_retire_ack", freeze_ack, 0);
        step();
        @(negedge clk);
        check("frozen_ack",   freeze_ack,     1);
        check("frozen_valid", bus.book_valid, 0);
        check("frozen_ready", bus.feed_ready, 0);
        step();
        @(negedge clk);
        check("frozen_ack_hold", freeze_ack, 1);
        step();
        freeze_req = 1'b0;
        @(negedge clk);
        check("unfreeze_ack_same", freeze_ack,     1);
        check("unfreeze_no_grant", bus.feed_ready, 0);
        step();
        @(negedge clk);
        check("unfreeze_ack_low", freeze_ack, 0);
        check("resume_grant", bus.feed_ready != 0, 1);
        step();

        // Earliest acknowledge: two cycles after freeze_req rises.
        bus.feed_valid = '0;
        freeze_req     = 1'b1;
        @(negedge clk);
        check("early_ack_c0", freeze_ack, 0);
        step();
        @(negedge clk);
        check("early_ack_c1", freeze_ack, 0);
        step();
        @(negedge clk);
        check("early_ack_c2", freeze_ack, 1);
        step();
        freeze_req = 1'b0;
        step();

        // Reset while an update is pending and ptr sits at 3.
        bus.feed_valid = 4'b0100;
        step();
        bus.feed_valid = '1;
        bus.book_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", bus.book_valid, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", bus.book_valid, 0);
        check("mid_rst_ready", bus.feed_ready, 0);
        step();
        rst            = 1'b0;
        bus.book_ready = 1'b1;
        @(negedge clk);
        check("post_rst_grant", bus.feed_ready, 4'b0001);
        step();

`ifdef ARB_STATS_EN
        // Saturation and clear-over-increment priority.
        bus.feed_valid = '0;
        stat_clr       = 1'b1;
        step();
        stat_clr       = 1'b0;
        bus.feed_valid = 4'b0010;
        repeat (20) step();
        @(negedge clk);
        check("stat_saturate", stat_count[1*CNT_W +: CNT_W], 15);
        step();
        stat_clr = 1'b1;
        @(negedge clk);
        check("stat_clr_transfer", bus.feed_ready, 4'b0010);
        step();
        stat_clr = 1'b0;
        @(negedge clk);
        check("stat_clr_result", stat_count[1*CNT_W +: CNT_W], 0);
        step();
`endif

        // Randomized traffic, freezes, backpressure and occasional resets.
        for (int c = 0; c < 2000; c++) begin
            bus.feed_valid = N'($urandom);
            bus.book_ready = ($urandom_range(0, 3) != 0);
            rand_payload();
            if ($urandom_range(0, 19) == 0) freeze_req = ~freeze_req;
            rst = ($urandom_range(0, 299) == 0);
`ifdef ARB_STATS_EN
            stat_clr = ($urandom_range(0, 49) == 0);
`endif
            step();
        end
        rst        = 1'b0;
        freeze_req = 1'b0;
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
